ahb_slave_mem_bridge: RTL

AHB-Lite responder that terminates transfers issued by the team's AHB masters (including multicycle-stretched masters) and converts each valid transfer into a single req/ack access on a simple word-wide memory/register back end. It generates byte enables and wait states, and produces the two-cycle AHB ERROR response. Error cases are unsupported size, misalignment, back-end error and back-end timeout. It sits at the slave end of the AHB fabric, in front of on-chip SRAM or register files.

---
 rtl/ahb_slave_mem_bridge_if.sv | 23 ++
 rtl/ahb_slave_mem_bridge.sv | 66 ++++++
 2 files changed

// File: rtl/ahb_slave_mem_bridge_if.sv
// ahb_slave_mem_bridge_if: AHB-Lite bus signals seen by a single responder
interface ahb_slave_mem_bridge_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_slave_mem_bridge.sv
// ahb_slave_mem_bridge: AHB-Lite responder turning each transfer into one req/ack back-end access
module ahb_slave_mem_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic                  hclk,
    input  logic                  reset,
    ahb_slave_mem_bridge_if.slave ahb_slv,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [29:0]           mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    input  logic                  mem_err
);
    typedef enum logic [2:0] {sIdle, sReq, sDone, sErr1, sErr2} state_t;
    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        open, accept, illegal;
    logic [3:0]  be;
    logic        unused_ok;
    assign unused_ok = ^{ahb_slv.hburst, ahb_slv.hprot};
    always_comb begin
        open       = state == sIdle || state == sDone || state == sErr2;
        accept     = open & ahb_slv.hsel & ahb_slv.hready & ahb_slv.htrans[1];
        illegal    = ahb_slv.hsize > 3'd2 || (ahb_slv.hsize == 3'd1 && ahb_slv.haddr[0]) ||
                     (ahb_slv.hsize == 3'd2 && |ahb_slv.haddr[1:0]);
        be         = ahb_slv.hsize == 3'd0 ? 4'b0001 << ahb_slv.haddr[1:0] :
                     ahb_slv.hsize == 3'd1 ? (ahb_slv.haddr[1] ? 4'b1100 : 4'b0011) :
                     ahb_slv.hsize == 3'd2 ? 4'b1111 : 4'b0000;
        mem_req    = state == sReq;
        mem_wdata  = ahb_slv.hwdata;
        ahb_slv.hreadyout = open;
        ahb_slv.hresp     = (state == sErr1 || state == sErr2) ? 2'b01 : 2'b00;
        state_nxt  = sIdle;
        case (state)
            sReq:    state_nxt = mem_ack ? (mem_err ? sErr1 : sDone) :
                                 cnt == 8'(TIMEOUT - 1) ? sErr1 : sReq;
            sErr1:   state_nxt = sErr2;
            default: state_nxt = accept ? (illegal ? sErr1 : sReq) : sIdle;
        endcase
    end
    always_ff @(posedge hclk) begin
        if (reset) state <= sIdle;
        else       state <= state_nxt;
    end
    // Request attributes are only loaded while ready, so they stay frozen through sReq.
    always_ff @(posedge hclk) begin
        if (reset) begin
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_be         <= '0;
            cnt            <= '0;
            ahb_slv.hrdata <= '0;
        end else begin
            if (accept) begin
                mem_we   <= ahb_slv.hwrite;
                mem_addr <= ahb_slv.haddr[31:2];
                mem_be   <= be;
            end
            cnt <= mem_req ? cnt + 8'd1 : 8'd0;
            if (mem_req && mem_ack && !mem_err && !mem_we) ahb_slv.hrdata <= mem_rdata;
        end
    end
endmodule
